// File: rtl/ula_seq_param.sv
// ula_seq_param: handshaked ALU with registered result and flags.
// Define ULA_MUL_EN to build the iterative shift-add multiplier (opcode 1011).
module ula_seq_param #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] entrada1,
  input  logic [WIDTH-1:0] entrada2,
  input  logic [3:0]       ALUControl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] resultado,
  output logic             zero,
  output logic             carry,
  output logic             overflow,
  output logic             negative,
  output logic             err
);

  localparam logic [3:0] OpAnd  = 4'b0000;
  localparam logic [3:0] OpOr   = 4'b0001;
  localparam logic [3:0] OpAdd  = 4'b0010;
  localparam logic [3:0] OpSub  = 4'b0011;
  localparam logic [3:0] OpSltu = 4'b0100;
  localparam logic [3:0] OpSlt  = 4'b0101;
  localparam logic [3:0] OpXor  = 4'b0110;
  localparam logic [3:0] OpNor  = 4'b0111;
  localparam logic [3:0] OpSll  = 4'b1000;
  localparam logic [3:0] OpSrl  = 4'b1001;
  localparam logic [3:0] OpSra  = 4'b1010;

`ifdef ULA_MUL_EN
  localparam logic [3:0] OpMul  = 4'b1011;
  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;
`else
  typedef enum logic [0:0] {StIdle, StDone} state_e;
`endif

  state_e state_q, state_d;

  logic [WIDTH-1:0] res_q, res_d;
  logic             zero_q, zero_d, carry_q, carry_d, ovf_q, ovf_d;
  logic             neg_q, neg_d, err_q, err_d;

  logic             accept;
  logic [WIDTH:0]   sum_ext, diff_ext;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c, alu_v, alu_err;

  assign accept   = in_valid && in_ready;
  assign sum_ext  = {1'b0, entrada1} + {1'b0, entrada2};
  assign diff_ext = {1'b0, entrada1} - {1'b0, entrada2};
  assign shamt    = entrada2[SHW-1:0];

  // Single-cycle datapath; diff_ext[WIDTH] is the unsigned borrow.
  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_err = 1'b0;
    case (ALUControl)
      OpAnd:  alu_res = entrada1 & entrada2;
      OpOr:   alu_res = entrada1 | entrada2;
      OpAdd: begin
        alu_res = sum_ext[WIDTH-1:0];
        alu_c   = sum_ext[WIDTH];
        alu_v   = (entrada1[WIDTH-1] == entrada2[WIDTH-1]) &&
                  (sum_ext[WIDTH-1] != entrada1[WIDTH-1]);
      end
      OpSub: begin
        alu_res = diff_ext[WIDTH-1:0];
        alu_c   = ~diff_ext[WIDTH];
        alu_v   = (entrada1[WIDTH-1] != entrada2[WIDTH-1]) &&
                  (diff_ext[WIDTH-1] != entrada1[WIDTH-1]);
      end
      OpSltu: alu_res = {{(WIDTH-1){1'b0}}, diff_ext[WIDTH]};
      OpSlt:  alu_res = {{(WIDTH-1){1'b0}}, $signed(entrada1) < $signed(entrada2)};
      OpXor:  alu_res = entrada1 ^ entrada2;
      OpNor:  alu_res = ~(entrada1 | entrada2);
      OpSll:  alu_res = entrada1 << shamt;
      OpSrl:  alu_res = entrada1 >> shamt;
      OpSra:  alu_res = $unsigned($signed(entrada1) >>> shamt);
      default: alu_err = 1'b1;
    endcase
  end

`ifdef ULA_MUL_EN
  logic [2*WIDTH-1:0] acc_q, acc_d, mcand_q, mcand_d, acc_sum;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [SHW-1:0]     cnt_q, cnt_d;
  logic               is_mul, mul_last;

  assign is_mul   = ALUControl == OpMul;
  assign acc_sum  = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign mul_last = cnt_q == SHW'(WIDTH - 1);

  // Multiplicand shifts left and multiplier right, so bit[count] is always mplier_q[0].
  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    if (state_q == StBusy) begin
      acc_d    = acc_sum;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + 1'b1;
    end else if (accept && is_mul) begin
      acc_d    = '0;
      mcand_d  = {{WIDTH{1'b0}}, entrada1};
      mplier_d = entrada2;
      cnt_d    = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    zero_d  = zero_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    neg_d   = neg_q;
    err_d   = err_q;
    case (state_q)
      StIdle, StDone: begin
        if (accept) begin
`ifdef ULA_MUL_EN
          if (is_mul) state_d = StBusy;
          else
`endif
          begin
            state_d = StDone;
            res_d   = alu_res;
            zero_d  = alu_res == '0;
            carry_d = alu_c;
            ovf_d   = alu_v;
            neg_d   = alu_res[WIDTH-1];
            err_d   = alu_err;
          end
        end else if (state_q == StDone && out_ready) begin
          state_d = StIdle;
        end
      end
`ifdef ULA_MUL_EN
      StBusy: begin
        if (mul_last) begin
          state_d = StDone;
          res_d   = acc_sum[WIDTH-1:0];
          zero_d  = acc_sum[WIDTH-1:0] == '0;
          carry_d = |acc_sum[2*WIDTH-1:WIDTH];
          ovf_d   = 1'b0;
          neg_d   = acc_sum[WIDTH-1];
          err_d   = 1'b0;
        end
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == StIdle) || (state_q == StDone && out_ready);
    out_valid = state_q == StDone;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      res_q   <= '0;
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      neg_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      res_q   <= res_d;
      zero_q  <= zero_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      neg_q   <= neg_d;
      err_q   <= err_d;
    end
  end

  assign resultado = res_q;
  assign zero      = zero_q;
  assign carry     = carry_q;
  assign overflow  = ovf_q;
  assign negative  = neg_q;
  assign err       = err_q;

endmodule
